// File: rtl/stopwatch_display_scan_if.sv
// Bundle between the stopwatch core (BCD time, run flag) and the board display pins.
// Signal names follow the board-level naming of the time bus and display pins.
interface stopwatch_display_scan_if;
  logic [16:1] Q;
  logic        RUN;
  logic [6:0]  SEG;
  logic        DP;
  logic [4:1]  AN;
  logic        FRAME;

  modport master (output Q, RUN, input  SEG, DP, AN, FRAME);
  modport slave  (input  Q, RUN, output SEG, DP, AN, FRAME);
endinterface

// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment scanner for the MM:SS stopwatch time bus.
// Snapshots the time once per frame so digits never tear; drives a blinking colon.
module stopwatch_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 125,
  parameter int LZB          = 1
) (
  input logic                      clk,
  input logic                      RESET_N,
  stopwatch_display_scan_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    case (v)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = 7'b0111111; // non-BCD nibble shows a dash
    endcase
  endfunction

  logic [PW-1:0] presc_q,  presc_d;
  logic [1:0]    idx_q,    idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          phase_q,  phase_d;
  logic [BW-1:0] blink_q,  blink_d;
  logic [6:0]    seg_q,    seg_d;
  logic          dp_q,     dp_d;
  logic [3:0]    an_q,     an_d;
  logic          frame_q,  frame_d;

  logic          tick;
  logic          frame_evt;
  logic [3:0]    nibble;

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // a stale value and infer a latch.
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    frame_evt = tick && (idx_q == 2'd3);

    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = frame_evt ? bus.Q : shadow_q;
    frame_d  = frame_evt;

    // Stopped: colon steady on. Running: toggle every BLINK_FRAMES frames.
    phase_d = phase_q;
    blink_d = blink_q;
    if (!bus.RUN) begin
      phase_d = 1'b1;
      blink_d = '0;
    end else if (frame_evt) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end

    case (idx_q)
      2'd0:    nibble = shadow_q[3:0];
      2'd1:    nibble = shadow_q[7:4];
      2'd2:    nibble = shadow_q[11:8];
      default: nibble = shadow_q[15:12];
    endcase

    seg_d = seg_encode(nibble);
    if ((LZB != 0) && (idx_q == 2'd3) && (nibble == 4'd0)) seg_d = 7'b1111111;

    // The first BLANK_CYC clocks of each slot keep every digit dark so the
    // previous digit's segments cannot ghost onto the next one.
    an_d = 4'b1111;
    if (presc_q >= BLANK_END) an_d[idx_q] = 1'b0;

    dp_d = ~((idx_q == 2'd2) && phase_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  // NOTE: the shadow is an ordinary 16-bit register, so it is reset along with
  // the rest; the display shows a defined 0 until the first snapshot.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      phase_q  <= 1'b1;
      blink_q  <= '0;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      an_q     <= 4'b1111;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.SEG   = seg_q;
  assign bus.DP    = dp_q;
  assign bus.AN    = an_q;
  assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Self-checking bench for stopwatch_display_scan: directed steps plus random
// time/run stimulus, checked against a cycle-count based display model.
module tb_stopwatch_display_scan;

  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int LZB          = 1;
  localparam int FRAME_CYC    = 4 * REFRESH_DIV;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stopwatch_display_scan_if bus ();

  stopwatch_display_scan #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES),
    .LZB          (LZB)
  ) dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: m_n is the number of clocks elapsed since reset release.
  int          m_n;
  logic [15:0] m_shadow;
  bit          m_phase;
  int          m_blink;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (clock %0d)", tag, obs, exp, m_n);
    end
  endtask

  task automatic model_reset();
    m_n      = 0;
    m_shadow = 16'h0000;
    m_phase  = 1'b1;
    m_blink  = 0;
  endtask

  // Predict what the coming edge registers, advance the model, then compare.
  task automatic step();
    int         slot;
    int         pos;
    logic [3:0] nib;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    logic       e_frame;

    slot = (m_n / REFRESH_DIV) % 4;
    pos  = m_n % REFRESH_DIV;
    nib  = m_shadow[slot*4 +: 4];

    e_an = 4'hF;
    if (pos >= BLANK_CYC) e_an[slot] = 1'b0;

    if (LZB != 0 && slot == 3 && nib == 4'd0) e_seg = 7'b1111111;
    else if (nib > 4'd9)                      e_seg = 7'b0111111;
    else                                      e_seg = SEG_LUT[nib];

    e_dp    = !(slot == 2 && m_phase);
    e_frame = ((m_n % FRAME_CYC) == FRAME_CYC - 1);

    if (e_frame) m_shadow = bus.Q;
    if (!bus.RUN) begin
      m_phase = 1'b1;
      m_blink = 0;
    end else if (e_frame) begin
      m_blink++;
      if (m_blink == BLINK_FRAMES) begin
        m_blink = 0;
        m_phase = !m_phase;
      end
    end
    m_n++;

    @(posedge clk);
    #1;
    check("an", 32'(bus.AN), 32'(e_an));
    if (e_an != 4'hF) check("seg", 32'(bus.SEG), 32'(e_seg));
    check("dp", 32'(bus.DP), 32'(e_dp));
    check("frame", 32'(bus.FRAME), 32'(e_frame));
    check("an_onehot", 32'($countones(~bus.AN) <= 1), 32'd1);
  endtask

  task automatic run_to(input int target);
    while (m_n < target) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},    32'(bus.AN),    32'h0000000F);
    check({tag, "_seg"},   32'(bus.SEG),   32'h0000007F);
    check({tag, "_dp"},    32'(bus.DP),    32'd1);
    check({tag, "_frame"}, 32'(bus.FRAME), 32'd0);
  endtask

  initial begin
    int          pulses;
    int          last_pulse;
    logic [15:0] rq;
    logic        dp_pat [5];

    dp_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state, then release with Q=1234.
    bus.Q   = 16'h1234;
    bus.RUN = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // First frame shows the zero shadow with digit 4 blanked.
    run_to(14);
    check("f0_d4_an",  32'(bus.AN),  32'h7);
    check("f0_d4_seg", 32'(bus.SEG), 32'h7F);
    run_to(16);
    check("first_frame", 32'(bus.FRAME), 32'd1);
    run_to(18);
    check("d1_an",  32'(bus.AN),  32'hE);
    check("d1_seg", 32'(bus.SEG), 32'(7'b0011001));
    run_to(22);
    check("d2_seg", 32'(bus.SEG), 32'(7'b0110000));
    run_to(26);
    check("d3_seg", 32'(bus.SEG), 32'(7'b0100100));
    run_to(30);
    check("d4_an",  32'(bus.AN),  32'h7);
    check("d4_seg", 32'(bus.SEG), 32'(7'b1111001));

    // Mid-frame change of Q must wait for the next snapshot.
    run_to(32);
    bus.Q = 16'h0959;
    run_to(54);
    bus.Q = 16'h1000;
    run_to(62);
    check("tear_d4_seg", 32'(bus.SEG), 32'h7F);
    run_to(66);
    check("new_d1_seg", 32'(bus.SEG), 32'(7'b1000000));
    run_to(78);
    check("new_d4_seg", 32'(bus.SEG), 32'(7'b1111001));

    // Invalid nibble shows a dash; all-zero time blanks digit 4 only.
    run_to(80);
    bus.Q = 16'h0A00;
    run_to(106);
    check("dash_an",  32'(bus.AN),  32'hB);
    check("dash_seg", 32'(bus.SEG), 32'(7'b0111111));
    check("dash_dp",  32'(bus.DP),  32'd0);
    bus.Q = 16'h0000;
    run_to(126);
    check("lzb_an",  32'(bus.AN),  32'h7);
    check("lzb_seg", 32'(bus.SEG), 32'h7F);

    // Running: colon on two frames, off two frames.
    bus.RUN = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_to(128 + f * FRAME_CYC + 10);
      check("blink_dp", 32'(bus.DP), 32'(dp_pat[f]));
    end
    // Stop while the colon is off: forced on without waiting for a frame.
    run_to(224 + 9);
    bus.RUN = 1'b0;
    run_to(224 + 11);
    check("stop_dp", 32'(bus.DP), 32'd0);

    // Asynchronous reset between edges mid-slot.
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    #1 rst_n = 1'b1;
    model_reset();
    bus.Q = 16'h4321;
    run_to(2);
    check("restart_an",  32'(bus.AN),  32'hE);
    check("restart_seg", 32'(bus.SEG), 32'(7'b1000000));

    // One FRAME pulse every 16 clocks over 10 frames.
    pulses     = 0;
    last_pulse = -1;
    for (int i = 0; i < 10 * FRAME_CYC; i++) begin
      step();
      if (bus.FRAME === 1'b1) begin
        if (last_pulse >= 0) check("frame_gap", 32'(m_n - last_pulse), 32'(FRAME_CYC));
        last_pulse = m_n;
        pulses++;
      end
    end
    check("frame_count", 32'(pulses), 32'd10);

    // Random time values and run toggles against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rq = 16'($urandom);
        if ($urandom_range(0, 1) == 0)
          rq = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        bus.Q = rq;
      end
      if ($urandom_range(0, 40) == 0) bus.RUN = ~bus.RUN;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
